uart_rx_deser: RTL and testbench
================================

Name: uart_rx_deser

Overview:
- Oversampling UART receiver. Converts the serial line driven by the simulation UART model (or a SoC UART transmitter) into bytes, and hands them over through a small FIFO with a valid/ready interface.
- It sits directly downstream of the serial TX pin. It is the consuming stage for the serial stream carried by uart_txd/uart_rxd in the testbench.
- Baud rate is set at run time by the same 16x divisor convention used by the UART model: 80 MHz / (16 * 115200) gives 43.

Parameters:
- FIFO_DEPTH, 4: receive FIFO entries; must be a power of two, 2 or more.
- DATA_BITS, 8: data bits per frame, LSB first.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset
- uart_rx_i  in  1  serial line, idle high, asynchronous to clk_i
- divisor_i  in  16  clocks per 1/16 bit; value 0 is treated as 1
- rx_data_o  out  DATA_BITS  byte at FIFO head
- rx_valid_o  out  1  FIFO non-empty
- rx_ready_i  in  1  consumer accepts head byte
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low
- overrun_o  out  1  one-cycle pulse: byte dropped because FIFO full
- busy_o  out  1  frame reception in progress (state is not IDLE)

Behaviour:
- Interface (already decided): one clock, clk_i; rst_i is asynchronous, active-high.
- Reset values:
  - rx_data_o=0, rx_valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
  - Synchronizer flops =1. FIFO empty. State IDLE. Prescaler and counters =0.
- Synchronizer:
  - 2-FF on uart_rx_i; all logic uses the synced value rxs.
  - Edge-to-FSM latency is 2 clocks.
- Prescaler:
  - 16-bit down-counter, reloads to max(divisor_i,1)-1.
  - tick asserts for 1 clock at each reload.
  - Free-running in IDLE is not required. It reloads on the start-edge detect, so the first tick comes divisor clocks after the edge.
  - A divisor_i change takes effect at the next reload.
- FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE.
  - IDLE: rxs==0 goes to START. Clear the 4-bit sample counter scnt and the bit counter.
  - START: on each tick, scnt++. At scnt==7 (mid-bit), rxs==1 means glitch: return to IDLE, no error. Otherwise reset scnt and go to DATA.
  - DATA: on each tick, scnt++. At scnt==15, shift rxs in at the MSB (LSB-first frame), bitcnt++. After DATA_BITS bits, go to STOP, or to PARITY if enabled.
  - STOP: at scnt==15, rxs==1 pushes the byte and returns to IDLE. rxs==0 pulses frame_err_o, discards the byte, and goes to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs==1, then go to IDLE. A break condition therefore produces exactly one error.
- FIFO:
  - Push and pop use pointers one bit wider than the index; wrap at FIFO_DEPTH.
  - rx_valid_o = !empty; rx_data_o = mem[rd_ptr] (registered memory, combinational head read).
  - Pop when rx_valid_o && rx_ready_i.
  - Push when full: if a pop happens in the same cycle, the push is accepted. Otherwise the byte is dropped and overrun_o pulses; FIFO contents are unchanged.
  - Push when empty with rx_ready_i high: rx_valid_o rises the next cycle. There is no bypass.
- Frame error and overrun never pulse in the same cycle.
- Reset mid-frame: immediate return to reset values, and the partial byte is lost. After release, a line that is still low is treated as a new start. This glitch-rejects if it is not a real start bit.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds input parity_odd_i (1=odd, 0=even) and output parity_err_o (1-cycle pulse).
  - PARITY state samples one bit at scnt==15 after the data bits.
  - A mismatch pulses parity_err_o in the STOP-sample cycle. The byte is still pushed if the stop bit is good.
- Undefined: no PARITY state, no extra ports; frame is 1 start + DATA_BITS + 1 stop.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enum typedef;
  - localparams OVERSAMPLE=16 and MID_SAMPLE=7;
  - the function computing the effective divisor (0 maps to 1).
- One sub-module is natural: uart_rx_fifo (parameterised sync FIFO with push/pop/full/empty). The FSM and prescaler stay in uart_rx_deser.

Test Plan:
- Frame timing: divisor_i=43, send 0xA5 8N1 (bit = 688 clocks), rx_ready_i=1. Expect rx_valid_o for 1 cycle, rx_data_o=0xA5, no error pulses. Expect busy_o high from ~2 clocks after the start edge until the stop sample.
- Glitch and back-to-back: drive a low glitch of 200 clocks on an idle line. Expect no push and a return to IDLE at mid-start. Then send 0x00, 0xFF, 0x3C back-to-back. Expect all three received in order.
- Framing error: send 0x55 with the stop bit low, then hold the line low for 5 bit times. Expect exactly one frame_err_o pulse, no push. Then send 0x81 and expect it received.
- Overrun: rx_ready_i=0, FIFO_DEPTH=4, send 5 bytes 0x01..0x05. Expect a single overrun_o pulse on byte 5. Then set rx_ready_i=1 and expect pops 0x01..0x04.
- Reset mid-frame: assert rst_i during DATA bit 3 of 0xC3. Expect all outputs return to reset values asynchronously and the FIFO to be empty. The next 0x7E is received correctly.
- Parity (with UART_RX_PARITY_EN): parity_odd_i=0, send 0x07 with parity bit 0. Expect parity_err_o pulse and 0x07 still pushed. Send 0x07 with parity bit 1: no error.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
// Optional parity support is enabled with the UART_RX_PARITY_EN macro.
package uart_rx_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    function automatic logic [15:0] eff_divisor(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received bytes; registered storage, combinational head read.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// 16x oversampling UART receiver: synchronizer, prescaler, frame FSM and receive FIFO.
// Define UART_RX_PARITY_EN to add a parity bit with parity_odd_i / parity_err_o.
module uart_rx_deser
    import uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 uart_rx_i,
    input  logic [15:0]          divisor_i,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd_i,
    output logic                 parity_err_o,
`endif
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [3:0]    SCNT_MID = 4'(MID_SAMPLE);
    localparam logic [3:0]    SCNT_END = 4'(OVERSAMPLE - 1);

    logic                 rx_meta;
    logic                 rxs;
    rx_state_t            state_q, state_d;
    logic [15:0]          pcnt_q, pcnt_d;
    logic [3:0]           scnt_q, scnt_d;
    logic [BW-1:0]        bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 ferr_d;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 tick;
    logic [15:0]          reload;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_d;
`endif

    assign reload = eff_divisor(divisor_i) - 16'd1;
    assign tick   = (state_q != ST_IDLE) && (pcnt_q == 16'd0);
    assign busy_o = (state_q != ST_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx_i;
            rxs     <= rx_meta;
        end
    end

    // Prescaler idles at zero and restarts on the start edge so the first tick is divisor clocks later.
    always_comb begin
        pcnt_d = pcnt_q;
        if (state_q == ST_IDLE) begin
            pcnt_d = rxs ? 16'd0 : reload;
        end else if (pcnt_q == 16'd0) begin
            pcnt_d = reload;
        end else begin
            pcnt_d = pcnt_q - 16'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        scnt_d   = scnt_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        ferr_d   = 1'b0;
        push     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
        perr_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                scnt_d   = '0;
                bitcnt_d = '0;
                if (!rxs) state_d = ST_START;
            end
            ST_START: begin
                if (tick) begin
                    if (scnt_q == SCNT_MID) begin
                        scnt_d  = '0;
                        state_d = rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        scnt_d = scnt_q + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == SCNT_END) begin
                        shreg_d  = {rxs, shreg_q[DATA_BITS-1:1]};
                        bitcnt_d = bitcnt_q + BW'(1);
                        if (bitcnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == SCNT_END) begin
                        par_d   = rxs;
                        state_d = ST_STOP;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == SCNT_END) begin
`ifdef UART_RX_PARITY_EN
                        perr_d = ((^shreg_q) ^ par_q) != parity_odd_i;
`endif
                        if (rxs) begin
                            push    = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_WAIT_IDLE;
                        end
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            pcnt_q      <= '0;
            scnt_q      <= '0;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_o <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            scnt_q      <= scnt_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            frame_err_o <= ferr_d;
            overrun_o   <= push && fifo_full && !pop;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_o <= perr_d;
`endif
        end
    end

    assign rx_valid_o = !fifo_empty;
    assign pop        = rx_valid_o && rx_ready_i;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .din   (shreg_q),
        .pop   (pop),
        .dout  (rx_data_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx_deser.sv
// Randomized self-checking bench for uart_rx_deser against a byte-queue reference model.
// Also exercises the parity variant when UART_RX_PARITY_EN is defined.
module tb_uart_rx_deser;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        uart_rx_i;
    logic [15:0] divisor_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic        frame_err_o;
    logic        overrun_o;
    logic        busy_o;
`ifdef UART_RX_PARITY_EN
    logic        parity_odd_i;
    logic        parity_err_o;
`endif

    uart_rx_deser #(.FIFO_DEPTH(4), .DATA_BITS(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .uart_rx_i   (uart_rx_i),
        .divisor_i   (divisor_i),
`ifdef UART_RX_PARITY_EN
        .parity_odd_i(parity_odd_i),
        .parity_err_o(parity_err_o),
`endif
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q [$];
    int held = 0;
    int n_ferr = 0, n_ovr = 0, n_perr = 0, n_both = 0;
    int n_pops = 0, n_unexp = 0, n_valid_cyc = 0;
    logic par_flip = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: bytes leave in send order; a full 4-entry FIFO with no consumer drops the byte.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (rx_valid_o) n_valid_cyc++;
            if (frame_err_o) n_ferr++;
            if (overrun_o) n_ovr++;
            if (frame_err_o && overrun_o) n_both++;
`ifdef UART_RX_PARITY_EN
            if (parity_err_o) n_perr++;
`endif
            if (rx_valid_o && rx_ready_i) begin
                n_pops++;
                if (exp_q.size() == 0) n_unexp++;
                else check_val("rx_data", {24'd0, rx_data_o}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    function automatic int bit_clks();
        return 16 * ((divisor_i == 16'd0) ? 1 : int'(divisor_i));
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic drive_bit(input logic b);
        uart_rx_i = b;
        wait_clks(bit_clks());
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ parity_odd_i ^ par_flip);
`endif
        drive_bit(stop_val);
    endtask

    task automatic expect_byte(input logic [7:0] d);
        if (!rx_ready_i && held >= 4) begin
        end else begin
            exp_q.push_back(d);
            if (!rx_ready_i) held++;
        end
    endtask

    initial begin
        int ferr0, ovr0, pops0, perr0;
        logic [7:0] seq [3];
        logic [7:0] rb;
        rst_i      = 1'b1;
        uart_rx_i  = 1'b1;
        rx_ready_i = 1'b1;
        divisor_i  = 16'd43;
`ifdef UART_RX_PARITY_EN
        parity_odd_i = 1'b0;
`endif
        wait_clks(3);
        check_val("rst_valid", {31'd0, rx_valid_o}, 32'd0);
        check_val("rst_data", {24'd0, rx_data_o}, 32'd0);
        check_val("rst_busy", {31'd0, busy_o}, 32'd0);
        check_val("rst_ferr", {31'd0, frame_err_o}, 32'd0);
        check_val("rst_ovr", {31'd0, overrun_o}, 32'd0);
        rst_i = 1'b0;
        wait_clks(5);

        // Frame timing at divisor 43 (688 clocks per bit).
        n_valid_cyc = 0;
        expect_byte(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_clks(1);
                check_val("busy_before_sync", {31'd0, busy_o}, 32'd0);
                wait_clks(4);
                check_val("busy_after_edge", {31'd0, busy_o}, 32'd1);
                wait_clks(6495);
                check_val("busy_before_stop", {31'd0, busy_o}, 32'd1);
                wait_clks(100);
                check_val("busy_after_stop", {31'd0, busy_o}, 32'd0);
            end
        join
        wait_clks(20);
        check_val("a5_valid_cycles", n_valid_cyc, 1);
        check_val("a5_ferr", n_ferr, 0);
        check_val("a5_ovr", n_ovr, 0);
        check_val("a5_drained", exp_q.size(), 0);

        // Low glitch shorter than half a bit.
        pops0 = n_pops;
        uart_rx_i = 1'b0;
        wait_clks(100);
        check_val("glitch_busy", {31'd0, busy_o}, 32'd1);
        wait_clks(100);
        uart_rx_i = 1'b1;
        wait_clks(300);
        check_val("glitch_idle", {31'd0, busy_o}, 32'd0);
        check_val("glitch_no_push", n_pops, pops0);

        divisor_i = 16'd4;
        wait_clks(10);
        seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            expect_byte(seq[i]);
            send_frame(seq[i], 1'b1);
        end
        wait_clks(20);
        check_val("b2b_drained", exp_q.size(), 0);
        check_val("b2b_pops", n_pops, pops0 + 3);

        // Framing error followed by a long break.
        ferr0 = n_ferr;
        pops0 = n_pops;
        send_frame(8'h55, 1'b0);
        wait_clks(5 * bit_clks());
        uart_rx_i = 1'b1;
        wait_clks(2 * bit_clks());
        check_val("ferr_once", n_ferr, ferr0 + 1);
        check_val("ferr_no_push", n_pops, pops0);
        expect_byte(8'h81);
        send_frame(8'h81, 1'b1);
        wait_clks(20);
        check_val("after_ferr_drained", exp_q.size(), 0);

        // Overrun with a stalled consumer.
        rx_ready_i = 1'b0;
        held = 0;
        ovr0 = n_ovr;
        pops0 = n_pops;
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) check_val("ovr_before_5th", n_ovr, ovr0);
            expect_byte(8'(i));
            send_frame(8'(i), 1'b1);
        end
        wait_clks(10);
        check_val("ovr_once", n_ovr, ovr0 + 1);
        check_val("ovr_valid", {31'd0, rx_valid_o}, 32'd1);
        check_val("ovr_head", {24'd0, rx_data_o}, 32'h01);
        rx_ready_i = 1'b1;
        held = 0;
        wait_clks(20);
        check_val("ovr_pops", n_pops, pops0 + 4);
        check_val("ovr_drained", exp_q.size(), 0);

        // Reset during data bit 3 of 0xC3 with a byte sitting in the FIFO.
        rx_ready_i = 1'b0;
        send_frame(8'h11, 1'b1);
        wait_clks(10);
        check_val("pre_rst_valid", {31'd0, rx_valid_o}, 32'd1);
        rb = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(rb[i]);
        uart_rx_i = rb[3];
        wait_clks(bit_clks() / 2);
        #2 rst_i = 1'b1;
        #1;
        check_val("mid_rst_valid", {31'd0, rx_valid_o}, 32'd0);
        check_val("mid_rst_data", {24'd0, rx_data_o}, 32'd0);
        check_val("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        wait_clks(3);
        rst_i = 1'b0;
        rx_ready_i = 1'b1;
        wait_clks(8);
        uart_rx_i = 1'b1;
        wait_clks(2 * bit_clks());
        check_val("post_rst_busy", {31'd0, busy_o}, 32'd0);
        check_val("post_rst_valid", {31'd0, rx_valid_o}, 32'd0);
        expect_byte(8'h7E);
        send_frame(8'h7E, 1'b1);
        wait_clks(20);
        check_val("post_rst_drained", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
        parity_odd_i = 1'b0;
        perr0 = n_perr;
        par_flip = 1'b1;
        expect_byte(8'h07);
        send_frame(8'h07, 1'b1);
        wait_clks(10);
        check_val("par_err_pulse", n_perr, perr0 + 1);
        par_flip = 1'b0;
        expect_byte(8'h07);
        send_frame(8'h07, 1'b1);
        wait_clks(10);
        check_val("par_ok", n_perr, perr0 + 1);
        check_val("par_drained", exp_q.size(), 0);
`else
        perr0 = 0;
`endif

        // Random bytes at random divisors, including the 0 -> 1 mapping.
        pops0 = n_pops;
        for (int i = 0; i < 12; i++) begin
            divisor_i = 16'($urandom_range(0, 5));
            rb = 8'($urandom);
            expect_byte(rb);
            send_frame(rb, 1'b1);
            wait_clks($urandom_range(0, 40));
        end
        wait_clks(100);
        check_val("rand_pops", n_pops, pops0 + 12);
        check_val("rand_drained", exp_q.size(), 0);
        check_val("unexpected_pops", n_unexp, 0);
        check_val("ferr_total", n_ferr, 1);
        check_val("ovr_total", n_ovr, 1);
        check_val("err_ovr_same_cycle", n_both, 0);
        check_val("final_busy", {31'd0, busy_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
